// File: rtl/itch_parse_collector.sv
`default_nettype none
// ============================================================================
// Module   : itch_parse_collector
// Purpose  : Output stage for the speculative ITCH decoder bank. Resolves
//            collisions between per-type decoder valid lanes, buffers accepted
//            records (with their source lane) in a FIFO drained over
//            ready/valid, and keeps saturating statistics counters.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            dec_valid         - per-lane 1-cycle valid pulses
//            dec_rec           - lane i record at [i*REC_W +: REC_W]
//            out_valid/ready   - head-of-FIFO handshake
//            out_rec, out_src  - head record and its lane index
//            fifo_level        - current occupancy
//            msg_cnt           - records pushed
//            collide_cnt       - cycles with more than one lane valid
//            drop_cnt          - records lost (full FIFO or mode-0 collision)
// Notes    : NUM_DEC must be >= 2; DEPTH must be a power of two, >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module itch_parse_collector #(
  parameter int NUM_DEC      = 6,
  parameter int REC_W        = 309,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int COLLIDE_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DEC-1:0]         dec_valid,
  input  logic [NUM_DEC*REC_W-1:0]   dec_rec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REC_W-1:0]           out_rec,
  output logic [$clog2(NUM_DEC)-1:0] out_src,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           msg_cnt,
  output logic [CNT_W-1:0]           collide_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SRC_W = $clog2(NUM_DEC);
  localparam int ENT_W = REC_W + SRC_W;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] collide_cnt_q, collide_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  logic             any_valid;
  logic             multi_hot;
  logic             cand_valid;
  logic [SRC_W-1:0] cand_idx;
  logic [REC_W-1:0] cand_rec;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Lowest set lane wins; for a one-hot input this is simply that lane.
  always_comb begin
    cand_idx = '0;
    cand_rec = '0;
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      if (dec_valid[i]) begin
        cand_idx = SRC_W'(i);
        cand_rec = dec_rec[i*REC_W +: REC_W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_valid  = |dec_valid;
  assign multi_hot  = |(dec_valid & (dec_valid - NUM_DEC'(1)));
  assign cand_valid = any_valid && (!multi_hot || (COLLIDE_MODE == 1));

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = cand_valid && (!fifo_full || pop);
  // Collision drop and full drop in the same cycle are one lost event.
  assign drop_evt   = (multi_hot && (COLLIDE_MODE == 0)) || (cand_valid && !push);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    msg_cnt_d     = msg_cnt_q;
    collide_cnt_d = collide_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    mem_d         = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {cand_idx, cand_rec};
      wr_ptr_d                = wr_ptr_q + PW'(1);
      msg_cnt_d               = sat_inc(msg_cnt_q);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (multi_hot) begin
      collide_cnt_d = sat_inc(collide_cnt_q);
    end
    if (drop_evt) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      msg_cnt_q     <= '0;
      collide_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      msg_cnt_q     <= msg_cnt_d;
      collide_cnt_q <= collide_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid             = !fifo_empty;
  assign {out_src, out_rec}    = mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level            = wr_ptr_q - rd_ptr_q;
  assign msg_cnt               = msg_cnt_q;
  assign collide_cnt           = collide_cnt_q;
  assign drop_cnt              = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_itch_parse_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_itch_parse_collector
// Purpose  : Directed self-checking bench for itch_parse_collector. Three
//            instances share the stimulus: mode 0, mode 1, and mode 0 with
//            4-bit counters for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_itch_parse_collector;

  localparam int NUM_DEC = 6;
  localparam int REC_W   = 309;
  localparam int DEPTH   = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_DEC-1:0]       dec_valid;
  logic [NUM_DEC*REC_W-1:0] dec_rec;
  logic                     out_ready;

  logic             o0_valid, o1_valid, o2_valid;
  logic [REC_W-1:0] o0_rec, o1_rec, o2_rec;
  logic [2:0]       o0_src, o1_src, o2_src;
  logic [3:0]       o0_lvl, o1_lvl, o2_lvl;
  logic [15:0]      o0_msg, o0_col, o0_drop;
  logic [15:0]      o1_msg, o1_col, o1_drop;
  logic [3:0]       o2_msg, o2_col, o2_drop;

  int n_checks = 0;
  int n_fail   = 0;

  itch_parse_collector #(.COLLIDE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rec(dec_rec),
    .out_valid(o0_valid), .out_ready(out_ready), .out_rec(o0_rec), .out_src(o0_src),
    .fifo_level(o0_lvl), .msg_cnt(o0_msg), .collide_cnt(o0_col), .drop_cnt(o0_drop)
  );

  itch_parse_collector #(.COLLIDE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rec(dec_rec),
    .out_valid(o1_valid), .out_ready(out_ready), .out_rec(o1_rec), .out_src(o1_src),
    .fifo_level(o1_lvl), .msg_cnt(o1_msg), .collide_cnt(o1_col), .drop_cnt(o1_drop)
  );

  itch_parse_collector #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rec(dec_rec),
    .out_valid(o2_valid), .out_ready(out_ready), .out_rec(o2_rec), .out_src(o2_src),
    .fifo_level(o2_lvl), .msg_cnt(o2_msg), .collide_cnt(o2_col), .drop_cnt(o2_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fields MSB first: type, order_ref, side, shares, price, new_order_ref, timestamp, misc.
  function automatic logic [REC_W-1:0] mkfields(
      input logic [3:0] typ, input logic [63:0] oref, input logic side,
      input logic [31:0] shares, input logic [31:0] price, input logic [63:0] nref,
      input logic [47:0] ts, input logic [63:0] misc);
    return {typ, oref, side, shares, price, nref, ts, misc};
  endfunction

  function automatic logic [REC_W-1:0] mkrec(input int k);
    logic [63:0] kk;
    kk = 64'(k);
    return mkfields(4'(k % 16), 64'hA000_0000_0000_0000 + kk, kk[0], 32'd100 + kk[31:0],
                    32'h0001_86A0 + kk[31:0], 64'h5500_0000_0000_0000 ^ kk,
                    48'h0000_0001_0000 + kk[47:0], 64'hDEAD_BEEF_0000_0000 | kk);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    dec_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int lane, input logic [REC_W-1:0] r);
    dec_valid       = '0;
    dec_valid[lane] = 1'b1;
    dec_rec[lane*REC_W +: REC_W] = r;
    tick();
    dec_valid = '0;
  endtask

  logic [REC_W-1:0] add_rec;

  initial begin
    rst       = 1'b0;
    dec_valid = '0;
    dec_rec   = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_valid", 512'(o0_valid), 512'(0));
    check_eq("rst_level", 512'(o0_lvl), 512'(0));
    check_eq("rst_msg",   512'(o0_msg), 512'(0));
    check_eq("rst_col",   512'(o0_col), 512'(0));
    check_eq("rst_drop",  512'(o0_drop), 512'(0));

    // Single add on lane 0, consumer ready
    add_rec   = mkfields(4'h1, 64'h42, 1'b0, 32'd100, 32'h0001_86A0, 64'h0, 48'h1234, 64'h0);
    out_ready = 1'b1;
    pulse(0, add_rec);
    check_eq("add_valid",  512'(o0_valid), 512'(1));
    check_eq("add_src",    512'(o0_src), 512'(0));
    check_eq("add_rec",    512'(o0_rec), 512'(add_rec));
    check_eq("add_shares", 512'(o0_rec[239:208]), 512'(100));
    check_eq("add_price",  512'(o0_rec[207:176]), 512'h186A0);
    check_eq("add_level",  512'(o0_lvl), 512'(1));
    check_eq("add_msg",    512'(o0_msg), 512'(1));
    tick();
    check_eq("add_popped", 512'(o0_valid), 512'(0));
    check_eq("add_level0", 512'(o0_lvl), 512'(0));

    // Overfill: 10 pulses into 8 entries with consumer stalled
    do_reset();
    for (int k = 0; k < 10; k++) pulse(k % NUM_DEC, mkrec(k));
    check_eq("fill_level", 512'(o0_lvl), 512'(8));
    check_eq("fill_drop",  512'(o0_drop), 512'(2));
    check_eq("fill_msg",   512'(o0_msg), 512'(8));
    check_eq("fill_hold",  512'(o0_rec), 512'(mkrec(0)));
    tick();
    check_eq("stall_hold_rec", 512'(o0_rec), 512'(mkrec(0)));
    check_eq("stall_hold_vld", 512'(o0_valid), 512'(1));
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check_eq($sformatf("drain_vld%0d", k), 512'(o0_valid), 512'(1));
      check_eq($sformatf("drain_rec%0d", k), 512'(o0_rec), 512'(mkrec(k)));
      check_eq($sformatf("drain_src%0d", k), 512'(o0_src), 512'(k % NUM_DEC));
      tick();
    end
    check_eq("drain_empty", 512'(o0_valid), 512'(0));
    check_eq("drain_level", 512'(o0_lvl), 512'(0));

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int k = 0; k < DEPTH; k++) pulse(k % NUM_DEC, mkrec(k));
    check_eq("full_level", 512'(o0_lvl), 512'(8));
    out_ready = 1'b1;
    pulse(1, mkrec(20));
    out_ready = 1'b0;
    check_eq("fullpp_level", 512'(o0_lvl), 512'(8));
    check_eq("fullpp_drop",  512'(o0_drop), 512'(0));
    check_eq("fullpp_msg",   512'(o0_msg), 512'(9));
    check_eq("fullpp_head",  512'(o0_rec), 512'(mkrec(1)));

    // Collision 6'b000101
    do_reset();
    dec_rec[0*REC_W +: REC_W] = mkrec(30);
    dec_rec[2*REC_W +: REC_W] = mkrec(32);
    dec_valid = 6'b000101;
    tick();
    dec_valid = '0;
    check_eq("m0_col",   512'(o0_col), 512'(1));
    check_eq("m0_drop",  512'(o0_drop), 512'(1));
    check_eq("m0_msg",   512'(o0_msg), 512'(0));
    check_eq("m0_level", 512'(o0_lvl), 512'(0));
    check_eq("m1_col",   512'(o1_col), 512'(1));
    check_eq("m1_drop",  512'(o1_drop), 512'(0));
    check_eq("m1_msg",   512'(o1_msg), 512'(1));
    check_eq("m1_valid", 512'(o1_valid), 512'(1));
    check_eq("m1_src",   512'(o1_src), 512'(0));
    check_eq("m1_rec",   512'(o1_rec), 512'(mkrec(30)));

    // Counter saturation with 4-bit counters
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) pulse(3, mkrec(40 + k));
    check_eq("sat_msg4",   512'(o2_msg), 512'(15));
    check_eq("sat_drop4",  512'(o2_drop), 512'(0));
    check_eq("sat_msg16",  512'(o0_msg), 512'(20));

    // Mid-stream reset drops queued entries
    do_reset();
    for (int k = 0; k < 3; k++) pulse(k, mkrec(50 + k));
    check_eq("mid_level3", 512'(o0_lvl), 512'(3));
    rst       = 1'b1;
    out_ready = 1'b1;
    dec_valid = 6'b000001;
    tick();
    rst       = 1'b0;
    dec_valid = '0;
    out_ready = 1'b0;
    check_eq("mid_valid", 512'(o0_valid), 512'(0));
    check_eq("mid_level", 512'(o0_lvl), 512'(0));
    check_eq("mid_msg",   512'(o0_msg), 512'(0));
    check_eq("mid_drop",  512'(o0_drop), 512'(0));
    pulse(2, mkrec(60));
    check_eq("post_valid", 512'(o0_valid), 512'(1));
    check_eq("post_src",   512'(o0_src), 512'(2));
    check_eq("post_rec",   512'(o0_rec), 512'(mkrec(60)));
    check_eq("post_msg",   512'(o0_msg), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
